// File: rtl/kpn_queue_write_arbiter_pkg.sv
// Shared constants and helpers for the KPN queue write arbiter.
// Optional statistics are enabled by defining KPN_ARB_STATS_EN.
package kpn_arb_pkg;

  localparam int unsigned STALL_W = 32;

  function automatic int unsigned fifo_depth(input int unsigned elements);
    return 32'd1 << elements;
  endfunction

  // One extra bit so a completely full FIFO (DEPTH) is representable.
  function automatic int unsigned occ_width(input int unsigned elements);
    return elements + 32'd1;
  endfunction

  function automatic int unsigned word_lsb(input int unsigned idx, input int unsigned bits);
    return idx * bits;
  endfunction

endpackage

// File: rtl/kpn_queue_write_arbiter_picker.sv
// Combinational round-robin picker: first eligible requester after `last`, wrapping.
module rr_priority_picker
  import kpn_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     onehot_o,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic found_s;

  // Scan last+1 .. last+N modulo N; the first eligible hit wins.
  always_comb begin
    onehot_o = '0;
    valid_o  = 1'b0;
    idx_o    = '0;
    found_s  = 1'b0;
    for (int k = 1; k <= int'(N); k++) begin
      int j;
      j = int'(last_i) + k;
      if (j >= int'(N)) begin
        j = j - int'(N);
      end else begin
        j = j;
      end
      if (!found_s && eligible_i[j]) begin
        found_s     = 1'b1;
        valid_o     = 1'b1;
        idx_o       = IDX_W'(j);
        onehot_o[j] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/kpn_queue_write_arbiter.sv
// Round-robin arbiter sharing one KPN FIFO write port, with credit tracking.
// Define KPN_ARB_STATS_EN to add the stall_cycles_o statistics output.
module kpn_queue_write_arbiter
  import kpn_arb_pkg::*;
#(
  parameter int unsigned BITS_NUMBER              = 16,
  parameter int unsigned FIFO_ELEMENTS            = 5,
  parameter int unsigned REQUESTERS               = 4,
  parameter int unsigned NUMBER_OF_PRECHARGE_DATA = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [REQUESTERS-1:0]             req_i,
  input  logic [REQUESTERS*BITS_NUMBER-1:0] req_data_i,
  output logic [REQUESTERS-1:0]             grant_o,
  output logic                              fifo_wr_o,
  output logic [BITS_NUMBER-1:0]            fifo_entry_o,
  input  logic                              fifo_rd_i,
  input  logic                              fifo_empty_i,
  output logic [FIFO_ELEMENTS:0]            occupancy_o
`ifdef KPN_ARB_STATS_EN
  ,
  output logic [STALL_W-1:0]                stall_cycles_o
`endif
);

  localparam int unsigned DEPTH = fifo_depth(FIFO_ELEMENTS);
  localparam int unsigned OCC_W = occ_width(FIFO_ELEMENTS);
  localparam int unsigned IDX_W = $clog2(REQUESTERS);

  logic [REQUESTERS-1:0]  grant_q, grant_d;
  logic                   wr_q, wr_d;
  logic [BITS_NUMBER-1:0] entry_q, entry_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic [IDX_W-1:0]       last_q, last_d;

  logic [REQUESTERS-1:0]  eligible_s;
  logic [REQUESTERS-1:0]  pick_onehot_s;
  logic                   pick_valid_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic                   space_s;
  logic                   issue_s;
  logic                   dec_s;

  // The requester granted this cycle is masked while it updates req/data.
  assign eligible_s = req_i & ~grant_q;
  assign space_s    = (occ_q < OCC_W'(DEPTH));
  assign issue_s    = pick_valid_s & space_s;
  assign dec_s      = fifo_rd_i & ~fifo_empty_i & (occ_q != '0);

  rr_priority_picker #(
    .N     (REQUESTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .eligible_i (eligible_s),
    .last_i     (last_q),
    .onehot_o   (pick_onehot_s),
    .valid_o    (pick_valid_s),
    .idx_o      (pick_idx_s)
  );

  always_comb begin
    grant_d = '0;
    wr_d    = 1'b0;
    entry_d = entry_q;
    last_d  = last_q;
    if (issue_s) begin
      grant_d = pick_onehot_s;
      wr_d    = 1'b1;
      entry_d = req_data_i[word_lsb(32'(pick_idx_s), BITS_NUMBER) +: BITS_NUMBER];
      last_d  = pick_idx_s;
    end else begin
      grant_d = '0;
      wr_d    = 1'b0;
    end
  end

  // A counted read and a write at the same edge cancel out.
  always_comb begin
    occ_d = occ_q;
    case ({issue_s, dec_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_q <= '0;
      wr_q    <= 1'b0;
      entry_q <= '0;
      occ_q   <= OCC_W'(NUMBER_OF_PRECHARGE_DATA);
      last_q  <= IDX_W'(REQUESTERS - 1);
    end else begin
      grant_q <= grant_d;
      wr_q    <= wr_d;
      entry_q <= entry_d;
      occ_q   <= occ_d;
      last_q  <= last_d;
    end
  end

  assign grant_o      = grant_q;
  assign fifo_wr_o    = wr_q;
  assign fifo_entry_o = entry_q;
  assign occupancy_o  = occ_q;

`ifdef KPN_ARB_STATS_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  // Count cycles where someone wants to write but the FIFO is full; saturate.
  always_comb begin
    stall_d = stall_q;
    if ((|eligible_s) && !space_s && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: doc/kpn_queue_write_arbiter.md
# kpn_queue_write_arbiter

Shares the single write port of one KPN `queue_module` FIFO among several producer processes. Arbitration is round-robin. The block keeps its own credit (occupancy) count, so it never issues a write the FIFO would drop. It sits between the producer processes and the FIFO's `wr`/`entry_1` inputs, and observes the FIFO's `rd`/`empty` side to recover credits.

## Interface

Parameters:
- `BITS_NUMBER`, 16: data word width; must match the FIFO.
- `FIFO_ELEMENTS`, 5: FIFO address width; capacity DEPTH = 2**FIFO_ELEMENTS.
- `REQUESTERS`, 4: number of producer ports, 2..16.
- `NUMBER_OF_PRECHARGE_DATA`, 0: words preloaded in the FIFO; this is the occupancy reset value; must be ≤ DEPTH.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req`  in  REQUESTERS: level request, one bit per producer.
- `req_data`  in  REQUESTERS*BITS_NUMBER: producer words, packed; requester i uses bits [i*BITS_NUMBER +: BITS_NUMBER].
- `grant`  out  REQUESTERS: registered, one-hot or zero; a one-cycle pulse means the word was accepted.
- `fifo_wr`  out  1: registered write strobe to the FIFO `wr`.
- `fifo_entry`  out  BITS_NUMBER: registered word to the FIFO `entry_1`.
- `fifo_rd`  in  1: the consumer's read strobe into the FIFO.
- `fifo_empty`  in  1: FIFO empty flag.
- `occupancy`  out  FIFO_ELEMENTS+1: credit count of committed, unread words.

## Operation

- **Eligibility.** Requester i is eligible when `req[i]`=1 and `grant[i]`=0 in the current cycle. Masking the requester granted this cycle prevents a double grant while it is still updating `req` and data.
- **Space.** A write may be issued when `occupancy` < DEPTH. Space is conservative: a simultaneous read does not free space in the same cycle.
- **Round-robin pick.** Search starts at `last+1`, modulo REQUESTERS, where `last` is the index of the most recent grant. The first eligible requester wins. `last` updates only when a grant is issued.
- **Issue.** When a requester wins and space is available, at the next edge:
  - `grant[winner]`=1, `fifo_wr`=1, `fifo_entry`=`req_data[winner]`.
  - Otherwise `grant`=0, `fifo_wr`=0, and `fifo_entry` holds its last value.
- **Occupancy update.**
  - inc = issuing write this cycle.
  - dec = `fifo_rd` & ~`fifo_empty`.
  - next = occ + inc − dec, so inc and dec together leave it unchanged.
  - A dec at occ=0 is ignored; the count saturates at 0 and never wraps.
  - occ never exceeds DEPTH, by construction.
- **Producer contract.** Hold `req` and data stable until `grant` is seen. The producer may drop `req` or present a new word on the cycle after the grant. Dropping `req` without a grant is legal; nothing is written.

## Timing

- **Reset values.** `grant`=0, `fifo_wr`=0, `fifo_entry`=0, `occupancy`=`NUMBER_OF_PRECHARGE_DATA`, `last`=REQUESTERS−1 so requester 0 has first priority.
- **Reset mid-operation.** A reset in the same cycle as a pending pick overrides it; nothing is issued. The FIFO must be reset alongside the arbiter, which is a system-level requirement.
- **Latency.** `req` sampled at edge k gives `grant`/`fifo_wr` high during cycle k+1. The FIFO stores the word at edge k+2.
- **Throughput.** Aggregate is 1 word/cycle with ≥2 active requesters. A single requester gets at most 1 word per 2 cycles because of the grant mask.
- **Full boundary.** At occ=DEPTH no grant is issued. The first cycle after a counted read (occ=DEPTH−1) grants at the next edge.
- **Wrap.** The round-robin index wraps from REQUESTERS−1 to 0.

## Configuration

- **`KPN_ARB_STATS_EN` defined.** Adds output port `stall_cycles`, 32 bits.
  - Increments every cycle in which some requester is eligible but occ=DEPTH.
  - Saturates at 2^32−1 and resets to 0.
- **Not defined.** The port and its counter are absent, and behaviour is otherwise identical.

## Structure

- **Package `kpn_arb_pkg`.**
  - Constant function for DEPTH from FIFO_ELEMENTS.
  - Occupancy-width constant.
  - Helper to extract word i from `req_data`.
- **Sub-module `rr_priority_picker`.** Combinational; inputs are the eligible vector and `last`; outputs are a one-hot winner plus a valid flag and winner index. Instantiated once.
- **Top level.** Holds the registers: `last`, `occupancy`, output regs, and the optional stall counter.

## Test plan

- **Reset defaults.** Hold `rst` 2 cycles with `req`=4'b1111. Outputs stay zero and `occupancy`=`NUMBER_OF_PRECHARGE_DATA`. The first grant after release is 4'b0001.
- **Rotation.** `req`=4'b1111, words 0xA000+i, FIFO never read. Grants run 0001, 0010, 0100, 1000, 0001 on consecutive cycles; `fifo_entry` runs 0xA000..0xA003; `occupancy` rises by 1 per cycle.
- **Single requester.** Only `req[2]` held high. Grants 0100 appear every other cycle.
- **Fill to full.** DEPTH=32, `NUMBER_OF_PRECHARGE_DATA`=4, no reads. Exactly 28 grants are issued, then `occupancy`=32 and grants stop. One `fifo_rd` with `fifo_empty`=0 produces exactly one further grant.
- **Simultaneous write and read.** At occ=10, a grant and a counted read in the same cycle leave occ=10. `fifo_rd` with `fifo_empty`=1 at occ=0 leaves occ=0.
- **Stall counter (`KPN_ARB_STATS_EN`).** Hold full with `req`=4'b0011 for 7 cycles. `stall_cycles`=7. The count is unchanged while `req`=0.
